// File: rtl/online_otf_convert.sv
// Borrow-save product word to two's-complement converter using on-the-fly Q/QM conversion, one digit per clock.
// Optional build macro OTF_INVALID_DIGIT_EN: flag the non-canonical 11 digit on err.
module online_otf_convert #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*N-1:0]   in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N:0]     result,
  output logic             err
);

  localparam int NDIG = 2 * N;
  localparam int ZW   = 4 * N;
  localparam int W    = 2 * N + 1;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [ZW-1:0]   sreg;
  logic [W-1:0]    q;
  logic [W-1:0]    qm;
  logic [CW-1:0]   cnt;
  logic [1:0]      dig;

  assign dig = sreg[ZW-1 -: 2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      q     <= '0;
      qm    <= '1;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= in_z;
            q     <= '0;
            qm    <= '1;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          // QM tracks Q-1 so a negative digit never needs a borrow chain
          case (dig)
            2'b10: begin
              q  <= {q[W-2:0], 1'b1};
              qm <= {q[W-2:0], 1'b0};
            end
            2'b01: begin
              q  <= {qm[W-2:0], 1'b1};
              qm <= {qm[W-2:0], 1'b0};
            end
            default: begin
              q  <= {q[W-2:0], 1'b0};
              qm <= {qm[W-2:0], 1'b1};
            end
          endcase
          sreg <= {sreg[ZW-3:0], 2'b00};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(NDIG - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready drops combinationally with rst so the reset cycle never accepts
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign result    = q;

`ifdef OTF_INVALID_DIGIT_EN
  logic err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      err_r <= 1'b0;
    end else if (state == CONV && dig == 2'b11) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule
